// File: rtl/nibble_packer.sv
// ---------------------------------------------------------------------------
// nibble_packer
//
// Upstream packing stage. Consecutive 4-bit nibbles are paired into 8-bit
// bytes and presented through a single output holding register. A nibble
// tagged in_last that arrives with no partner is flushed immediately. The
// missing half is filled with PAD, and the byte is flagged with out_partial.
//
// Parameters:
//   HI_FIRST - 1: first nibble -> byte[7:4], second -> byte[3:0]; 0: reverse
//   PAD      - filler nibble used when an odd trailing nibble is flushed
//   CNT_W    - width of the delivered-byte counter (wraps silently)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_valid    in_nibble / in_last are valid
//   in_ready    stage can take a nibble this cycle (combinational)
//   in_nibble   data nibble
//   in_last     final nibble of a burst, qualified by in_valid
//   out_valid   out_byte holds a packed byte
//   out_ready   downstream accepts the byte
//   out_byte    packed byte (registered)
//   out_field   out_byte[3:2], a slice for the downstream slicing stage
//   out_partial out_byte was produced by a pad flush
//   byte_cnt    number of bytes delivered, modulo 2**CNT_W
// ---------------------------------------------------------------------------
module nibble_packer #(
  parameter bit          HI_FIRST = 1'b1,
  parameter logic [3:0]  PAD      = 4'b0000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_nibble,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic [1:0]       out_field,
  output logic             out_partial,
  output logic [CNT_W-1:0] byte_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] held;
  logic       accept;
  logic       deliver;

  // Orders a (first, second) nibble pair into a byte.
  function automatic logic [7:0] pair(input logic [3:0] first,
                                      input logic [3:0] second);
    return HI_FIRST ? {first, second} : {second, first};
  endfunction

  // A full register can still take a nibble when it is being drained in
  // the same cycle, which gives one byte per cycle on back-to-back flushes.
  assign in_ready  = (state != FULL) || out_ready;
  assign out_valid = (state == FULL);
  assign out_field = out_byte[3:2];

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  // NOTE: every register here is updated with <= so that all of them see
  // the pre-edge values of state/held, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      held        <= 4'h0;
      out_byte    <= 8'h00;
      out_partial <= 1'b0;
      byte_cnt    <= '0;
    end else begin
      if (deliver) begin
        byte_cnt <= byte_cnt + 1'b1;
      end

      unique case (state)
        EMPTY: begin
          if (accept) begin
            if (in_last) begin
              out_byte    <= pair(in_nibble, PAD);
              out_partial <= 1'b1;
              state       <= FULL;
            end else begin
              held  <= in_nibble;
              state <= HALF;
            end
          end
        end

        HALF: begin
          // in_last on the second nibble just closes the pair; no pad.
          if (accept) begin
            out_byte    <= pair(held, in_nibble);
            out_partial <= 1'b0;
            state       <= FULL;
          end
        end

        FULL: begin
          // A nibble can only be accepted here together with a delivery,
          // and it is then treated as if the stage were already empty.
          if (deliver) begin
            if (accept && in_last) begin
              out_byte    <= pair(in_nibble, PAD);
              out_partial <= 1'b1;
              state       <= FULL;
            end else if (accept) begin
              held        <= in_nibble;
              out_partial <= 1'b0;
              state       <= HALF;
            end else begin
              out_partial <= 1'b0;
              state       <= EMPTY;
            end
          end
        end

        default: begin
          state       <= EMPTY;
          out_partial <= 1'b0;
        end
      endcase
    end
  end

endmodule
